// File: rtl/bin2bcd_seq_if.sv
// Handshake/result bundle between a value producer and the binary-to-BCD converter.
// The master drives the request side; the slave (converter) drives status and result.
interface bin2bcd_seq_if #(
  parameter int BIN_W = 14
);
  logic             start;
  logic [BIN_W-1:0] bin;
  logic             busy;
  logic             done;
  logic [15:0]      bcd;
  logic             ovf;

  modport master (
    output start, bin,
    input  busy, done, bcd, ovf
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, ovf
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative shift-and-add-3 (double dabble) binary-to-BCD converter.
// Produces a 4-digit packed BCD word for the 7-segment display driver.
// One bit is processed per clock; the result is held between conversions,
// and values above 9999 saturate to 9999 with ovf set.
module bin2bcd_seq #(
  parameter int BIN_W = 14
) (
  input  logic          clk,
  input  logic          rstn,
  bin2bcd_seq_if.slave  bus
);

  localparam int SR_W  = 16 + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             last;
  logic [SR_W-1:0]  sr;
  logic [SR_W-1:0]  sr_nxt;
  logic [CNT_W-1:0] cnt;
  logic [BIN_W-1:0] bin_lat;
  logic             busy_r;
  logic             done_r;
  logic [15:0]      bcd_r;
  logic             ovf_r;

  // One double-dabble iteration: correct every BCD nibble that would
  // overflow a decimal digit when doubled, then shift the register left.
  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] val);
    logic [SR_W-1:0] adj;
    adj = val;
    for (int i = 0; i < 4; i++) begin
      if (adj[BIN_W + 4*i +: 4] >= 4'd5)
        adj[BIN_W + 4*i +: 4] = adj[BIN_W + 4*i +: 4] + 4'd3;
    end
    return {adj[SR_W-2:0], 1'b0};
  endfunction

  // Clamp to 9999 when the original value does not fit in four digits.
  // Only a 14-bit input can exceed 9999, so for narrower inputs the
  // condition is constant-false and the clamp disappears.
  function automatic logic [16:0] saturate(input logic [BIN_W-1:0] val,
                                           input logic [15:0]      digits);
    if (BIN_W >= 14 && 32'(val) > 32'd9999)
      return {1'b1, 16'h9999};
    return {1'b0, digits};
  endfunction

  // Next-state decode. The DONE exit edge doubles as an accept opportunity,
  // which is what allows one conversion every BIN_W+1 cycles with start held.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    sr_nxt    = dabble_step(sr);
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST_CNT) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Shift register, iteration counter, latched input and registered outputs.
  // bcd/ovf are written only on the final iteration so they stay stable for
  // the display driver throughout the next conversion.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr      <= '0;
      cnt     <= '0;
      bin_lat <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      bcd_r   <= 16'h0000;
      ovf_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (accept) begin
        sr      <= {16'h0000, bus.bin};
        bin_lat <= bus.bin;
        cnt     <= '0;
        busy_r  <= 1'b1;
      end else if (state == SHIFT) begin
        sr  <= sr_nxt;
        cnt <= cnt + CNT_W'(1);
        if (last) begin
          {ovf_r, bcd_r} <= saturate(bin_lat, sr_nxt[SR_W-1 -: 16]);
          done_r         <= 1'b1;
          busy_r         <= 1'b0;
        end
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.bcd  = bcd_r;
  assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: table-driven vectors, hand-written
// multi-cycle corner cases, and a randomized back-to-back run compared
// against an arithmetic decimal-digit reference model.
module tb_bin2bcd_seq;

  localparam int BIN_W = 14;
  localparam int LAT   = BIN_W;

  logic clk = 1'b0;
  logic rstn;

  always #10 clk = ~clk;

  bin2bcd_seq_if #(.BIN_W(BIN_W)) bus ();

  bin2bcd_seq #(.BIN_W(BIN_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          bin;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs [12];

  // Reference: decimal digits by division, clamped above 9999. Returns {ovf, bcd}.
  function automatic logic [16:0] ref_model(input int v);
    if (v > 9999) return {1'b1, 16'h9999};
    return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called right after the accept edge; returns cycles until done and how
  // many sampled cycles had busy high (including the one after accept).
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = -1;
    busy_cnt = bus.busy ? 1 : 0;
    for (int n = 1; n <= 40; n++) begin
      tick;
      if (bus.done) begin
        lat = n;
        break;
      end
      if (bus.busy) busy_cnt++;
    end
  endtask

  task automatic convert(input string tag, input int v,
                         input logic [15:0] exp_bcd, input logic exp_ovf);
    int lat;
    int bc;
    bus.bin   = BIN_W'(v);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.bin   = BIN_W'($urandom);
    wait_done(lat, bc);
    check({tag, " latency"}, lat, LAT);
    check({tag, " busy cycles"}, bc, LAT);
    check({tag, " bcd"}, bus.bcd, exp_bcd);
    check({tag, " ovf"}, bus.ovf, exp_ovf);
    tick;
    check({tag, " done width"}, bus.done, 1'b0);
  endtask

  initial begin
    int lat;
    int bc;
    int dcount;
    int q [$];
    int v;
    int pushed;
    int got;
    int cyc;
    int last_done;
    logic [16:0] exp;

    vecs[0]  = '{0,     16'h0000, 1'b0};
    vecs[1]  = '{1,     16'h0001, 1'b0};
    vecs[2]  = '{9,     16'h0009, 1'b0};
    vecs[3]  = '{10,    16'h0010, 1'b0};
    vecs[4]  = '{99,    16'h0099, 1'b0};
    vecs[5]  = '{100,   16'h0100, 1'b0};
    vecs[6]  = '{999,   16'h0999, 1'b0};
    vecs[7]  = '{1000,  16'h1000, 1'b0};
    vecs[8]  = '{9999,  16'h9999, 1'b0};
    vecs[9]  = '{10000, 16'h9999, 1'b1};
    vecs[10] = '{16383, 16'h9999, 1'b1};
    vecs[11] = '{42,    16'h0042, 1'b0};

    // Reset state
    rstn      = 1'b0;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (3) tick;
    check("reset busy", bus.busy, 1'b0);
    check("reset done", bus.done, 1'b0);
    check("reset bcd",  bus.bcd,  16'h0000);
    check("reset ovf",  bus.ovf,  1'b0);
    rstn = 1'b1;
    tick;

    // Basic conversion and result hold
    convert("c1234", 1234, 16'h1234, 1'b0);
    repeat (100) tick;
    check("hold bcd", bus.bcd, 16'h1234);
    check("hold ovf", bus.ovf, 1'b0);

    // Table sweep including saturation and recovery
    for (int i = 0; i < 12; i++)
      convert($sformatf("vec%0d", vecs[i].bin), vecs[i].bin, vecs[i].bcd, vecs[i].ovf);

    // Starts during a conversion are dropped; start at accept+15 is taken
    bus.bin   = BIN_W'(500);
    bus.start = 1'b1;
    tick;
    dcount = 0;
    for (int c = 1; c <= LAT; c++) begin
      bus.start = (c == 5 || c == LAT);
      bus.bin   = BIN_W'(777);
      tick;
      if (bus.done) dcount++;
      if (c == LAT) begin
        check("ign done at k+14", bus.done, 1'b1);
        check("ign bcd 500", bus.bcd, 16'h0500);
      end
    end
    check("ign single done", dcount, 1);
    bus.start = 1'b1;
    bus.bin   = BIN_W'(777);
    tick;
    bus.start = 1'b0;
    check("b2b done cleared", bus.done, 1'b0);
    check("b2b accepted busy", bus.busy, 1'b1);
    wait_done(lat, bc);
    check("b2b latency", lat, LAT);
    check("b2b bcd 777", bus.bcd, 16'h0777);
    tick;

    // Reset in the middle of a conversion
    convert("c4321", 4321, 16'h4321, 1'b0);
    bus.bin   = BIN_W'(9876);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    repeat (7) tick;
    rstn = 1'b0;
    #1;
    check("midrst busy", bus.busy, 1'b0);
    check("midrst done", bus.done, 1'b0);
    check("midrst bcd",  bus.bcd,  16'h0000);
    check("midrst ovf",  bus.ovf,  1'b0);
    tick;
    tick;
    rstn = 1'b1;
    dcount = 0;
    for (int c = 0; c < 30; c++) begin
      tick;
      if (bus.done) dcount++;
    end
    check("midrst no done", dcount, 0);
    check("midrst bcd held", bus.bcd, 16'h0000);

    // Randomized back-to-back run with start held high
    v = $urandom_range(0, 16383);
    q.push_back(v);
    bus.bin   = BIN_W'(v);
    bus.start = 1'b1;
    pushed    = 1;
    got       = 0;
    cyc       = 0;
    last_done = -1;
    while (got < 2000 && cyc < 2000 * 15 + 200) begin
      tick;
      cyc++;
      if (bus.done) begin
        exp = ref_model(q.pop_front());
        check("rand bcd", bus.bcd, exp[15:0]);
        check("rand ovf", bus.ovf, exp[16]);
        if (last_done >= 0) check("rand period", cyc - last_done, LAT + 1);
        last_done = cyc;
        got++;
        if (pushed < 2000) begin
          case ($urandom_range(0, 9))
            0:       v = 9999;
            1:       v = 10000;
            2:       v = 0;
            3:       v = 16383;
            default: v = $urandom_range(0, 16383);
          endcase
          q.push_back(v);
          bus.bin = BIN_W'(v);
          pushed++;
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    check("rand conversions", got, 2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
